// File: rtl/md_scheduler_pkg.sv
// Shared definitions for the HI/LO multiply/divide scheduler.
//  md_op_e    : encoding of the E-stage multiply/divide operation field
//  md_state_e : sequencing states of the scheduler FSM
package md_scheduler_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5,
        MD_MFHI  = 3'd6,
        MD_MFLO  = 3'd7
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

endpackage

// File: rtl/md_arith.sv
// Combinational multiply/divide datapath.
//  op    : operation (only MULT/MULTU/DIV/DIVU produce a result)
//  a, b  : operands (a = rs, b = rt)
//  hi,lo : 64-bit product halves, or remainder (hi) / quotient (lo)
//  div0  : divide op with a zero divisor; hi/lo are 0 and must not be committed
module md_arith
    import md_scheduler_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  md_op_e           op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div0
);

    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   dvd_s;
    logic [WIDTH-1:0]   dvs_s;
    logic [WIDTH-1:0]   quot_s;
    logic [WIDTH-1:0]   rem_s;

    // Result selection; signed divide works on magnitudes and fixes signs afterwards.
    always_comb begin
        hi     = '0;
        lo     = '0;
        div0   = 1'b0;
        prod_s = '0;
        dvd_s  = '0;
        dvs_s  = '0;
        quot_s = '0;
        rem_s  = '0;
        case (op)
            MD_MULT: begin
                // Sign-extending to 2*WIDTH makes the truncated product the signed one.
                prod_s   = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
                {hi, lo} = prod_s;
            end
            MD_MULTU: begin
                prod_s   = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
                {hi, lo} = prod_s;
            end
            MD_DIV: begin
                if (b == '0) begin
                    div0 = 1'b1;
                end else begin
                    // The most negative dividend keeps its bit pattern, which as an
                    // unsigned magnitude is still correct.
                    dvd_s  = a[WIDTH-1] ? (~a + {{(WIDTH-1){1'b0}}, 1'b1}) : a;
                    dvs_s  = b[WIDTH-1] ? (~b + {{(WIDTH-1){1'b0}}, 1'b1}) : b;
                    quot_s = dvd_s / dvs_s;
                    rem_s  = dvd_s % dvs_s;
                    lo = (a[WIDTH-1] ^ b[WIDTH-1]) ? (~quot_s + {{(WIDTH-1){1'b0}}, 1'b1}) : quot_s;
                    hi = a[WIDTH-1] ? (~rem_s + {{(WIDTH-1){1'b0}}, 1'b1}) : rem_s;
                end
            end
            MD_DIVU: begin
                if (b == '0) begin
                    div0 = 1'b1;
                end else begin
                    lo = a / b;
                    hi = a % b;
                end
            end
            default: begin
                hi = '0;
                lo = '0;
            end
        endcase
    end

endmodule

// File: rtl/md_scheduler.sv
// HI/LO multiply/divide scheduler for the 5-stage pipeline.
//  clk, reset   : rising-edge clock, asynchronous active-low reset
//  E_start      : E-stage holds a qualified mult/multu/div/divu
//  E_mdop       : md_op_e encoding of the E-stage MD op
//  E_mdwrite    : E-stage holds mthi/mtlo
//  E_rs, E_rt   : forwarded operands
//  D_is_md      : D-stage holds any MD-class instruction
//  busy         : unit occupied (includes the E_start cycle)
//  md_stall     : freeze request for an MD instruction in D
//  HI, LO       : architectural registers
//  E_mdout      : HI for mfhi, LO for mflo, else 0
// The result is computed at the start edge and parked in pend_*; the FSM then
// counts the op's latency down and commits on the edge where the count is 1,
// so new HI/LO appear exactly 'latency' edges after the start edge.
module md_scheduler
    import md_scheduler_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             E_start,
    input  logic [2:0]       E_mdop,
    input  logic             E_mdwrite,
    input  logic [WIDTH-1:0] E_rs,
    input  logic [WIDTH-1:0] E_rt,
    input  logic             D_is_md,
    output logic             busy,
    output logic             md_stall,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic [WIDTH-1:0] E_mdout
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] MULT_LAT = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LAT  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    md_op_e             op_s;
    md_state_e          state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   start_lat_s;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;
    logic [WIDTH-1:0]   pend_hi_r;
    logic [WIDTH-1:0]   pend_lo_r;
    logic [WIDTH-1:0]   arith_hi_s;
    logic [WIDTH-1:0]   arith_lo_s;
    logic               div0_s;

    assign op_s = md_op_e'(E_mdop);

    md_arith #(.WIDTH(WIDTH)) u_arith (
        .op   (op_s),
        .a    (E_rs),
        .b    (E_rt),
        .hi   (arith_hi_s),
        .lo   (arith_lo_s),
        .div0 (div0_s)
    );

    // Busy length of the operation being started.
    always_comb begin
        start_lat_s = MULT_LAT;
        case (op_s)
            MD_DIV, MD_DIVU: start_lat_s = DIV_LAT;
            default:         start_lat_s = MULT_LAT;
        endcase
    end

    // IDLE/RUN sequencer owning HI, LO and the pending result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            cnt_r     <= '0;
            hi_r      <= '0;
            lo_r      <= '0;
            pend_hi_r <= '0;
            pend_lo_r <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (E_start) begin
                        // A zero divisor re-commits the current HI/LO, so the
                        // registers are unchanged after the full divide latency.
                        pend_hi_r <= div0_s ? hi_r : arith_hi_s;
                        pend_lo_r <= div0_s ? lo_r : arith_lo_s;
                        cnt_r     <= start_lat_s;
                        state_r   <= ST_RUN;
                    end else if (E_mdwrite) begin
                        case (op_s)
                            MD_MTHI: hi_r <= E_rs;
                            MD_MTLO: lo_r <= E_rs;
                            default: hi_r <= hi_r;
                        endcase
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    // Starts/writes arriving here are protocol violations and are ignored.
                    cnt_r <= cnt_r - CNT_ONE;
                    if (cnt_r == CNT_ONE) begin
                        hi_r    <= pend_hi_r;
                        lo_r    <= pend_lo_r;
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= '0;
                end
            endcase
        end
    end

    // mfhi/mflo read path; the D-stage stall keeps reads out of RUN.
    always_comb begin
        E_mdout = '0;
        case (op_s)
            MD_MFHI: E_mdout = hi_r;
            MD_MFLO: E_mdout = lo_r;
            default: E_mdout = '0;
        endcase
    end

    assign busy     = E_start | (state_r == ST_RUN);
    assign md_stall = D_is_md & busy;
    assign HI       = hi_r;
    assign LO       = lo_r;

endmodule

// File: tb/tb_md_scheduler.sv
// Directed self-checking bench for md_scheduler (default parameters: 32/5/10).
// Busy/stall lengths are counted in the cycles following the start edge.
module tb_md_scheduler;
    import md_scheduler_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        E_start;
    logic [2:0]  E_mdop;
    logic        E_mdwrite;
    logic [31:0] E_rs;
    logic [31:0] E_rt;
    logic        D_is_md;
    logic        busy;
    logic        md_stall;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] E_mdout;

    int total = 0;
    int bad   = 0;
    int viol  = 0;
    int mcnt  = 0;

    always #5 clk = ~clk;

    md_scheduler dut (
        .clk       (clk),
        .reset     (reset),
        .E_start   (E_start),
        .E_mdop    (E_mdop),
        .E_mdwrite (E_mdwrite),
        .E_rs      (E_rs),
        .E_rt      (E_rt),
        .D_is_md   (D_is_md),
        .busy      (busy),
        .md_stall  (md_stall),
        .HI        (HI),
        .LO        (LO),
        .E_mdout   (E_mdout)
    );

    // Independent occupancy model: flags any start/write issued while the unit runs.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mcnt <= 0;
        end else if (mcnt != 0) begin
            if (E_start || E_mdwrite) viol <= viol + 1;
            mcnt <= mcnt - 1;
        end else if (E_start) begin
            mcnt <= (E_mdop == MD_DIV || E_mdop == MD_DIVU) ? 10 : 5;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic d_md);
        step();
        E_start = 1'b1; E_mdop = op; E_rs = a; E_rt = b; D_is_md = d_md;
        @(negedge clk);
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL busy_on_start: got %b want 1", busy); end
        total++;
        if (md_stall !== d_md) begin bad++; $display("FAIL stall_on_start: got %b want %b", md_stall, d_md); end
        step();
        E_start = 1'b0; E_mdop = MD_MULT; E_rs = 32'h0; E_rt = 32'h0;
    endtask

    // Counts busy cycles after the start edge; remembers HI/LO seen while busy.
    task automatic run_len(output int n, output logic [31:0] hi_last, output logic [31:0] lo_last);
        n = 0; hi_last = HI; lo_last = LO;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy !== 1'b1) break;
            n++; hi_last = HI; lo_last = LO;
            step();
        end
    endtask

    task automatic check_op(input string name, input int n_exp, input logic [31:0] old_hi,
                            input logic [31:0] old_lo, input logic [31:0] hi_exp,
                            input logic [31:0] lo_exp);
        int n; logic [31:0] hl; logic [31:0] ll;
        run_len(n, hl, ll);
        total++;
        if (n !== n_exp) begin bad++; $display("FAIL %s_busy_len: got %0d want %0d", name, n, n_exp); end
        total++;
        if ({hl, ll} !== {old_hi, old_lo}) begin
            bad++; $display("FAIL %s_early_commit: got %h_%h want %h_%h", name, hl, ll, old_hi, old_lo);
        end
        total++;
        if (HI !== hi_exp) begin bad++; $display("FAIL %s_hi: got %h want %h", name, HI, hi_exp); end
        total++;
        if (LO !== lo_exp) begin bad++; $display("FAIL %s_lo: got %h want %h", name, LO, lo_exp); end
    endtask

    task automatic test_reset();
        reset = 1'b0; E_start = 1'b0; E_mdwrite = 1'b0; E_mdop = MD_MFHI;
        E_rs = 32'h0; E_rt = 32'h0; D_is_md = 1'b1;
        @(negedge clk);
        total++;
        if ({busy, md_stall} !== 2'b00) begin bad++; $display("FAIL reset_busy_stall: got %b want 00", {busy, md_stall}); end
        total++;
        if ({HI, LO} !== 64'h0) begin bad++; $display("FAIL reset_hilo: got %h want 0", {HI, LO}); end
        total++;
        if (E_mdout !== 32'h0) begin bad++; $display("FAIL reset_mdout: got %h want 0", E_mdout); end
        step();
        reset = 1'b1; D_is_md = 1'b0; E_mdop = MD_MULT;
    endtask

    task automatic test_reset_mid_run();
        logic seen;
        start_op(MD_MULT, 32'hFFFF_FFFF, 32'h2, 1'b0);
        step();
        #2 reset = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
        total++;
        if ({HI, LO} !== 64'h0) begin bad++; $display("FAIL midrst_hilo: got %h want 0", {HI, LO}); end
        step();
        reset = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (busy !== 1'b0 || HI !== 32'h0 || LO !== 32'h0) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin bad++; $display("FAIL midrst_late_commit: got %b want 0", seen); end
    endtask

    task automatic test_mult();
        start_op(MD_MULT, 32'hFFFF_FFFF, 32'h2, 1'b0);
        check_op("mult", 5, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        start_op(MD_MULTU, 32'hFFFF_FFFF, 32'h2, 1'b0);
        check_op("multu", 5, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFFE);
    endtask

    task automatic test_div();
        start_op(MD_DIV, 32'hFFFF_FFF9, 32'h2, 1'b0);
        check_op("div", 10, 32'h1, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        start_op(MD_DIVU, 32'h7, 32'h0, 1'b0);
        check_op("divu0", 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        start_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        check_op("divovf", 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h0, 32'h8000_0000);
    endtask

    task automatic test_stall_mflo();
        int n;
        start_op(MD_MULT, 32'h3, 32'h5, 1'b1);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (md_stall !== 1'b1) break;
            n++;
            step();
        end
        total++;
        if (n !== 5) begin bad++; $display("FAIL stall_len: got %0d want 5", n); end
        step();
        D_is_md = 1'b0; E_mdop = MD_MFLO;
        @(negedge clk);
        total++;
        if (E_mdout !== 32'd15) begin bad++; $display("FAIL mflo_read: got %h want %h", E_mdout, 32'd15); end
        E_mdop = MD_MFHI;
        #1;
        total++;
        if (E_mdout !== 32'h0) begin bad++; $display("FAIL mfhi_read: got %h want 0", E_mdout); end
        E_mdop = MD_MULT;
    endtask

    task automatic test_mt();
        step();
        E_mdwrite = 1'b1; E_mdop = MD_MTHI; E_rs = 32'h1234;
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL mthi_busy: got %b want 0", busy); end
        step();
        E_mdwrite = 1'b0; E_mdop = MD_MFHI; E_rs = 32'h0;
        @(negedge clk);
        total++;
        if ({busy, HI, LO} !== {1'b0, 32'h1234, 32'd15}) begin
            bad++; $display("FAIL mthi_commit: got %b_%h_%h want 0_00001234_0000000f", busy, HI, LO);
        end
        total++;
        if (E_mdout !== 32'h1234) begin bad++; $display("FAIL mfhi_after_mthi: got %h want 00001234", E_mdout); end
        step();
        E_mdwrite = 1'b1; E_mdop = MD_MTLO; E_rs = 32'hA5A5_0F0F;
        step();
        E_mdwrite = 1'b0; E_mdop = MD_MFLO; E_rs = 32'h0;
        @(negedge clk);
        total++;
        if ({HI, E_mdout} !== {32'h1234, 32'hA5A5_0F0F}) begin
            bad++; $display("FAIL mtlo_commit: got %h_%h want 00001234_a5a50f0f", HI, E_mdout);
        end
        E_mdop = MD_DIVU;
        #1;
        total++;
        if (E_mdout !== 32'h0) begin bad++; $display("FAIL mdout_nonread: got %h want 0", E_mdout); end
        E_mdop = MD_MULT;
    endtask

    task automatic test_back_to_back();
        int n;
        start_op(MD_MULT, 32'h6, 32'h7, 1'b1);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (md_stall !== 1'b1) break;
            n++;
            step();
        end
        total++;
        if (n !== 5) begin bad++; $display("FAIL b2b_stall_len: got %0d want 5", n); end
        total++;
        if ({HI, LO} !== {32'h0, 32'd42}) begin bad++; $display("FAIL b2b_first: got %h_%h want 0_2a", HI, LO); end
        start_op(MD_DIV, 32'd100, 32'd7, 1'b0);
        check_op("b2b_div", 10, 32'h0, 32'd42, 32'd2, 32'd14);
        total++;
        if (viol !== 0) begin bad++; $display("FAIL protocol_violation: got %0d want 0", viol); end
    endtask

    initial begin
        test_reset();
        test_reset_mid_run();
        test_mult();
        test_div();
        test_stall_mflo();
        test_mt();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
